// File: rtl/uart_pkg.sv
// Shared constants and sizing helper for the UART baud-rate generator.
package uart_pkg;

  localparam int unsigned UART_CNT_W      = 16;
  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DIV_RESET  = 13;

  // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_mod_counter.sv
// Modulo counter: counts 0..term_i while enabled, wraps to 0 and pulses wrap_o on the wrapping edge.
module uart_mod_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [Width-1:0] term_i,
  output logic             wrap_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i & ~clr_i & (cnt_q == term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == term_i) ? '0 : cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Baud-rate tick generator: oversample tick, baud tick and legacy divided clock.
// Optional fractional divisor enabled by defining UART_BAUD_FRAC_EN.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W      = UART_CNT_W,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DIV_RESET  = UART_DIV_RESET
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  input  logic             sync_clr,
`ifdef UART_BAUD_FRAC_EN
  input  logic [3:0]       frac_val,
`endif
  output logic             tick_os,
  output logic             tick_baud,
  output logic             clk_out,
  output logic [CNT_W-1:0] div_cur
);

  localparam int unsigned OsW = cnt_width(OVERSAMPLE);

  logic [CNT_W-1:0] div_q, div_d;
  logic             tick_os_q, tick_os_d;
  logic             tick_baud_q, tick_baud_d;
  logic             clk_q, clk_d;
  logic             cnt_clr;
  logic             pre_en;
  logic             pre_wrap;
  logic             os_wrap;

  assign cnt_clr = div_load | sync_clr;

`ifdef UART_BAUD_FRAC_EN
  logic [3:0] facc_q, facc_d;
  logic       pend_q, pend_d;
  logic [4:0] facc_sum;

  // A carry inserts one idle enabled cycle at the start of the next period.
  assign pre_en   = en & ~pend_q;
  assign facc_sum = {1'b0, facc_q} + {1'b0, frac_val};

  always_comb begin
    facc_d = facc_q;
    pend_d = pend_q;
    if (cnt_clr) begin
      facc_d = '0;
      pend_d = 1'b0;
    end else if (pre_wrap) begin
      facc_d = facc_sum[3:0];
      pend_d = facc_sum[4];
    end else if (en && pend_q) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      facc_q <= '0;
      pend_q <= 1'b0;
    end else begin
      facc_q <= facc_d;
      pend_q <= pend_d;
    end
  end
`else
  assign pre_en = en;
`endif

  uart_mod_counter #(
    .Width (CNT_W)
  ) u_prescale (
    .clk_i  (clk_in),
    .rst_ni (rst_n),
    .en_i   (pre_en),
    .clr_i  (cnt_clr),
    .term_i (div_q),
    .wrap_o (pre_wrap)
  );

  uart_mod_counter #(
    .Width (OsW)
  ) u_oversample (
    .clk_i  (clk_in),
    .rst_ni (rst_n),
    .en_i   (pre_wrap),
    .clr_i  (cnt_clr),
    .term_i (OsW'(OVERSAMPLE - 1)),
    .wrap_o (os_wrap)
  );

  always_comb begin
    div_d       = div_q;
    clk_d       = clk_q;
    tick_os_d   = 1'b0;
    tick_baud_d = 1'b0;
    if (div_load) begin
      div_d = div_val;
      clk_d = 1'b0;
    end else if (!sync_clr) begin
      tick_os_d   = pre_wrap;
      tick_baud_d = os_wrap;
      if (pre_wrap) begin
        clk_d = ~clk_q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      div_q       <= CNT_W'(DIV_RESET);
      tick_os_q   <= 1'b0;
      tick_baud_q <= 1'b0;
      clk_q       <= 1'b0;
    end else begin
      div_q       <= div_d;
      tick_os_q   <= tick_os_d;
      tick_baud_q <= tick_baud_d;
      clk_q       <= clk_d;
    end
  end

  assign tick_os   = tick_os_q;
  assign tick_baud = tick_baud_q;
  assign clk_out   = clk_q;
  assign div_cur   = div_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Randomised bench for uart_baud_gen against an event-level reference model.
module tb_uart_baud_gen;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] div_val;
  logic        div_load;
  logic        sync_clr;
  logic [3:0]  frac_val;
  logic        tick_os;
  logic        tick_baud;
  logic        clk_out;
  logic [15:0] div_cur;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model: count enabled edges left until the next tick; ticks numbered since last clear.
  int unsigned m_div;
  int unsigned m_left;
  int unsigned m_nt;
  int unsigned m_facc;
  bit          m_clk;
  bit          m_tos;
  bit          m_tb;

  always #5 clk_in = ~clk_in;

  uart_baud_gen dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (en),
    .div_val   (div_val),
    .div_load  (div_load),
    .sync_clr  (sync_clr),
`ifdef UART_BAUD_FRAC_EN
    .frac_val  (frac_val),
`endif
    .tick_os   (tick_os),
    .tick_baud (tick_baud),
    .clk_out   (clk_out),
    .div_cur   (div_cur)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    int unsigned sum;
    int unsigned carry;
    m_tos = 1'b0;
    m_tb  = 1'b0;
    if (!rst_n) begin
      m_div  = 13;
      m_left = 14;
      m_nt   = 0;
      m_facc = 0;
      m_clk  = 1'b0;
    end else if (div_load) begin
      m_div  = div_val;
      m_left = m_div + 1;
      m_nt   = 0;
      m_facc = 0;
      m_clk  = 1'b0;
    end else if (sync_clr) begin
      m_left = m_div + 1;
      m_nt   = 0;
      m_facc = 0;
    end else if (en) begin
      m_left--;
      if (m_left == 0) begin
        m_tos = 1'b1;
        m_nt++;
        m_tb  = (m_nt % 16) == 0;
        m_clk = ~m_clk;
        carry = 0;
`ifdef UART_BAUD_FRAC_EN
        sum    = m_facc + frac_val;
        carry  = sum / 16;
        m_facc = sum % 16;
`else
        sum    = 0;
`endif
        m_left = m_div + 1 + carry;
      end
    end
  endtask

  // Inputs are set at the falling edge before calling; outputs compared at the next falling edge.
  task automatic step();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check_eq("tick_os", {31'd0, tick_os}, {31'd0, m_tos});
    check_eq("tick_baud", {31'd0, tick_baud}, {31'd0, m_tb});
    check_eq("clk_out", {31'd0, clk_out}, {31'd0, m_clk});
    check_eq("div_cur", {16'd0, div_cur}, m_div);
  endtask

  task automatic idle();
    rst_n    = 1'b1;
    en       = 1'b1;
    div_load = 1'b0;
    sync_clr = 1'b0;
  endtask

  task automatic run(input int unsigned n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int unsigned r;
    rst_n    = 1'b0;
    en       = 1'b0;
    div_val  = '0;
    div_load = 1'b0;
    sync_clr = 1'b0;
    frac_val = '0;
    run(3);

    // Defaults: divide by 14, baud every 224.
    idle();
    run(500);

    // Divisor 3.
    div_val = 16'd3; div_load = 1'b1; run(1); idle();
    run(150);

    // Divisor 0.
    div_val = 16'd0; div_load = 1'b1; run(1); idle();
    run(40);

    // en dropped for 10 cycles at pcnt=5 with divisor 13.
    div_val = 16'd13; div_load = 1'b1; run(1); idle();
    run(5);
    en = 1'b0; run(10);
    en = 1'b1; run(30);

    // Load and clear together mid-count, then reset mid-count.
    run(6);
    div_val = 16'd7; div_load = 1'b1; sync_clr = 1'b1; run(1); idle();
    run(20);
    rst_n = 1'b0; run(1); idle();
    run(20);

    // Fractional divisor 9 + 8/16 (frac_val is ignored unless the feature is built).
    div_val = 16'd9; frac_val = 4'd8; div_load = 1'b1; run(1); idle();
    run(340);

    // Random mix of loads, clears, enable gaps and occasional reset.
    for (int i = 0; i < 6000; i++) begin
      r        = $urandom_range(0, 999);
      rst_n    = (r != 0);
      div_load = (r >= 1 && r < 8);
      sync_clr = (r >= 6 && r < 14);
      en       = ($urandom_range(0, 9) != 0);
      if (div_load) begin
        div_val  = 16'($urandom_range(0, 20));
        frac_val = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
